mem_line_responder: RTL and testbench

Memory-side responder for the cache line-fill protocol. Accepts line requests from a cache (I-cache or D-cache), tags each with a transaction ID and queues them in a request FIFO. After a fixed service latency it returns the full line with the matching ID, and holds the response until the requester acknowledges it. The block sits between the cache miss ports and the backing line store, and is the response end of the cache's enable/ID/ack handshake.

---
 rtl/mem_line_responder.sv | 208 ++++++++++++++++++++
 tb/tb_mem_line_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// mem_line_responder: memory-side responder for cache line fills.
// Each accepted request is tagged with an incrementing ID and queued in a
// small FIFO. Requests are answered in order, each after LATENCY cycles,
// with the line read from the backing store. A response is held until the
// requester acknowledges it.
// Optional feature: define MEM_RESP_TIMEOUT_EN to drop a response that is
// not acknowledged within TIMEOUT cycles. This build also adds o_timeout.
module mem_line_responder #(
    parameter int  PA_WIDTH     = 32,
    parameter int  N_BYTES      = 16,
    parameter int  ID_WIDTH     = 4,
    parameter int  MEM_LINES    = 256,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  LATENCY      = 3,
    parameter int  TIMEOUT      = 16,
    localparam int LINE_WIDTH   = N_BYTES * 8,
    localparam int OFFSET_WIDTH = $clog2(N_BYTES),
    localparam int LIDX_WIDTH   = $clog2(MEM_LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_req_enable,
    input  logic [PA_WIDTH-1:0]   i_req_addr,
    output logic [ID_WIDTH-1:0]   o_id_request,
    output logic                  o_in_use,
    output logic                  o_resp_enable,
    output logic [LINE_WIDTH-1:0] o_resp_data,
    output logic [ID_WIDTH-1:0]   o_resp_id,
    input  logic                  i_resp_ack,
    input  logic                  i_load_en,
    input  logic [LIDX_WIDTH-1:0] i_load_idx,
    input  logic [LINE_WIDTH-1:0] i_load_data
`ifdef MEM_RESP_TIMEOUT_EN
    ,
    output logic                  o_timeout
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int LAT_W = $clog2(LATENCY + 1);

    localparam logic [1:0] M_IDLE = 2'd0;
    localparam logic [1:0] M_WAIT = 2'd1;
    localparam logic [1:0] M_RESP = 2'd2;

    logic [LINE_WIDTH-1:0] mem_q       [MEM_LINES];
    logic [LIDX_WIDTH-1:0] fifo_lidx_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0]   fifo_id_q   [FIFO_DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [ID_WIDTH-1:0]   id_req_q;
    logic [1:0]            state_q, state_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic                  resp_en_q;
    logic [LINE_WIDTH-1:0] resp_data_q;
    logic [ID_WIDTH-1:0]   resp_id_q;
    logic                  in_use, push, ack_pop, pop, load_resp;
    logic                  unused_addr;

    // Full is decoded from the registered count only, so a pop on the same
    // edge never frees a slot early and o_in_use has no input path.
    assign in_use  = (count_q == CNT_W'(FIFO_DEPTH));
    assign push    = i_req_enable && !in_use;
    assign ack_pop = (state_q == M_RESP) && i_resp_ack;
    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    // Only the line-index field of the address is used.
    assign unused_addr = ^i_req_addr;

`ifdef MEM_RESP_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_q;
    logic             tmo_fire, tmo_pulse_q;

    // An ack on the final cycle wins over the timeout.
    assign tmo_fire = (state_q == M_RESP) && !i_resp_ack &&
                      (tmo_q == TMO_W'(TIMEOUT - 1));
    assign pop      = ack_pop || tmo_fire;

    // Count unacknowledged cycles in M_RESP and pulse o_timeout on a drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
        end else begin
            tmo_pulse_q <= tmo_fire;
            if (load_resp) begin
                tmo_q <= '0;
            end else if ((state_q == M_RESP) && !pop) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

    assign o_timeout = tmo_pulse_q;
`else
    assign pop = ack_pop;
`endif

    // Backing line store, written by the preload port. It is not reset.
    always_ff @(posedge clk) begin
        if (i_load_en) begin
            mem_q[i_load_idx] <= i_load_data;
        end
    end

    // FIFO payload storage. Only the pointers carry reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_lidx_q[wr_ptr_q] <= i_req_addr[OFFSET_WIDTH +: LIDX_WIDTH];
            fifo_id_q[wr_ptr_q]   <= id_req_q;
        end
    end

    // FIFO pointers, occupancy and the next-ID counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            id_req_q <= '0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                id_req_q <= id_req_q + ID_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Service FSM next state. The latency countdown starts on the edge where
    // an entry becomes head, so the response rises LATENCY edges later.
    always_comb begin
        state_d   = state_q;
        lat_d     = lat_q;
        load_resp = 1'b0;
        case (state_q)
            M_IDLE: begin
                if (count_d != '0) begin
                    state_d = M_WAIT;
                    lat_d   = LAT_W'(LATENCY - 1);
                end
            end
            M_WAIT: begin
                if (lat_q == '0) begin
                    state_d   = M_RESP;
                    load_resp = 1'b1;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            M_RESP: begin
                if (pop) begin
                    if (count_d != '0) begin
                        state_d = M_WAIT;
                        lat_d   = LAT_W'(LATENCY - 1);
                    end else begin
                        state_d = M_IDLE;
                    end
                end
            end
            default: begin
                state_d = M_IDLE;
                lat_d   = '0;
            end
        endcase
    end

    // FSM state and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= M_IDLE;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
        end
    end

    // Capture the head's line and ID on entry to M_RESP, and hold them until
    // the pop. A preload on the capture edge is not seen in that response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_en_q   <= 1'b0;
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else if (load_resp) begin
            resp_en_q   <= 1'b1;
            resp_data_q <= mem_q[fifo_lidx_q[rd_ptr_q]];
            resp_id_q   <= fifo_id_q[rd_ptr_q];
        end else if (pop) begin
            resp_en_q <= 1'b0;
        end
    end

    assign o_id_request  = id_req_q;
    assign o_in_use      = in_use;
    assign o_resp_enable = resp_en_q;
    assign o_resp_data   = resp_data_q;
    assign o_resp_id     = resp_id_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder with default parameters.
// Expected responses are pushed to a scoreboard when a request is accepted.
// They are popped and compared when the response rises. A small timing model
// tracks occupancy, the next ID and the expected rise edge.
module tb_mem_line_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;
    localparam int TMO   = 16;

    typedef struct packed {
        logic [3:0]   id;
        logic [127:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req_en = 1'b0;
    logic [31:0]  req_addr = '0;
    logic         resp_ack = 1'b0;
    logic         load_en = 1'b0;
    logic [7:0]   load_idx = '0;
    logic [127:0] load_data = '0;

    logic [3:0]   o_id_request;
    logic         o_in_use;
    logic         o_resp_enable;
    logic [127:0] o_resp_data;
    logic [3:0]   o_resp_id;
`ifdef MEM_RESP_TIMEOUT_EN
    logic         o_timeout;
`endif

    mem_line_responder dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_enable  (req_en),
        .i_req_addr    (req_addr),
        .o_id_request  (o_id_request),
        .o_in_use      (o_in_use),
        .o_resp_enable (o_resp_enable),
        .o_resp_data   (o_resp_data),
        .o_resp_id     (o_resp_id),
        .i_resp_ack    (resp_ack),
        .i_load_en     (load_en),
        .i_load_idx    (load_idx),
        .i_load_data   (load_data)
`ifdef MEM_RESP_TIMEOUT_EN
        ,
        .o_timeout     (o_timeout)
`endif
    );

    always #5 clk = ~clk;

    // Model and scoreboard state.
    logic [127:0] store_m [256];
    exp_t         sb[$];
    exp_t         cur;
    int           occ = 0;
    logic [3:0]   exp_id = '0;
    int           phase = 0;          // 0 none, 1 waiting, 2 response valid
    int           edge_n = 0;
    int           h_edge = 0;
    int           resp_edges = 0;
    int           acc_total = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the current inputs.
    // Update the model, then check all outputs 1 time unit after the edge.
    task automatic tick();
        logic acc, popd, tmo_e;
        logic [7:0] lidx;
        int nocc;
        edge_n++;
        acc   = req_en && (occ != DEPTH);
        popd  = 1'b0;
        tmo_e = 1'b0;
        lidx  = req_addr[4 +: 8];
        if (phase == 2) begin
            if (resp_ack) begin
                popd = 1'b1;
            end else begin
                resp_edges++;
`ifdef MEM_RESP_TIMEOUT_EN
                if (resp_edges == TMO) begin
                    popd  = 1'b1;
                    tmo_e = 1'b1;
                end
`endif
            end
        end
        if (acc) begin
            sb.push_back({exp_id, store_m[lidx]});
            $display("accept id=%0d lidx=%0d edge=%0d", exp_id, lidx, edge_n);
            exp_id = exp_id + 4'd1;
            acc_total++;
        end
        nocc = occ + int'(acc) - int'(popd);
        if (phase == 2 && popd) begin
            if (nocc > 0) begin
                phase  = 1;
                h_edge = edge_n;
            end else begin
                phase = 0;
            end
        end else if (phase == 0 && acc) begin
            phase  = 1;
            h_edge = edge_n;
        end
        occ = nocc;
        if (load_en) store_m[load_idx] = load_data;

        @(posedge clk);
        #1;

        if (phase == 1 && (edge_n - h_edge) >= LAT) begin
            phase      = 2;
            resp_edges = 0;
            chk("sb_has_entry", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) cur = sb.pop_front();
            $display("response id=%0d data=%h edge=%0d", o_resp_id, o_resp_data, edge_n);
        end
        chk("resp_enable", 128'(o_resp_enable), 128'(phase == 2));
        if (phase == 2) begin
            chk("resp_id", 128'(o_resp_id), 128'(cur.id));
            chk("resp_data", o_resp_data, cur.data);
        end
        chk("in_use", 128'(o_in_use), 128'(occ == DEPTH));
        chk("id_request", 128'(o_id_request), 128'(exp_id));
`ifdef MEM_RESP_TIMEOUT_EN
        chk("timeout", 128'(o_timeout), 128'(tmo_e));
`endif
    endtask

    // Apply an asynchronous reset, check the reset values while it is held,
    // then release it just after an edge.
    task automatic do_reset();
        req_en   = 1'b0;
        resp_ack = 1'b0;
        load_en  = 1'b0;
        rst_n    = 1'b0;
        #2;
        chk("rst_id_request", 128'(o_id_request), 128'(0));
        chk("rst_in_use", 128'(o_in_use), 128'(0));
        chk("rst_resp_enable", 128'(o_resp_enable), 128'(0));
        chk("rst_resp_data", o_resp_data, 128'(0));
        chk("rst_resp_id", 128'(o_resp_id), 128'(0));
`ifdef MEM_RESP_TIMEOUT_EN
        chk("rst_timeout", 128'(o_timeout), 128'(0));
`endif
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        occ        = 0;
        exp_id     = '0;
        phase      = 0;
        resp_edges = 0;
        sb.delete();
        $display("reset applied at edge %0d", edge_n);
    endtask

    initial begin
        #1;
        do_reset();

        // Preload every line so that any request returns known data.
        load_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            load_idx  = i[7:0];
            load_data = {$urandom, $urandom, $urandom, $urandom};
            if (i == 5) load_data = 128'h00112233_44556677_8899AABB_CCDDEEFF;
            tick();
        end
        load_en = 1'b0;

        // Single request to line 5, acknowledged immediately.
        resp_ack = 1'b1;
        req_addr = 32'h50;
        req_en   = 1'b1;
        tick();
        req_en = 1'b0;
        repeat (6) tick();

        // Fill the FIFO with no ack, hold the response, then release one
        // slot. The held fifth request should enter after the pop.
        do_reset();
        req_en = 1'b1;
        repeat (4) begin
            req_addr = $urandom;
            tick();
        end
        repeat (10) tick();
        resp_ack = 1'b1;
        tick();
        resp_ack = 1'b0;
        tick();
        req_en   = 1'b0;
        resp_ack = 1'b1;
        repeat (30) tick();

        // Ack and a new accept on the same edge with three entries queued.
        resp_ack = 1'b0;
        req_en   = 1'b1;
        repeat (3) begin
            req_addr = $urandom;
            tick();
        end
        req_en = 1'b0;
        for (int k = 0; k < 20 && phase != 2; k++) tick();
        chk("reached_resp", 128'(phase), 128'(2));
        req_en   = 1'b1;
        req_addr = $urandom;
        resp_ack = 1'b1;
        tick();
        resp_ack = 1'b0;
        req_addr = $urandom;
        tick();
        req_en   = 1'b0;
        resp_ack = 1'b1;
        repeat (30) tick();

        // Seventeen accepts: the ID wraps from 15 to 0.
        do_reset();
        resp_ack  = 1'b1;
        acc_total = 0;
        for (int k = 0; k < 200 && acc_total < 17; k++) begin
            req_en   = 1'b1;
            req_addr = $urandom;
            if (acc_total == 16) req_en = 1'b1;
            tick();
            if (acc_total >= 17) req_en = 1'b0;
        end
        req_en = 1'b0;
        chk("accept_count", 128'(acc_total), 128'(17));
        repeat (30) tick();

        // Reset while waiting with three entries queued. The store survives.
        do_reset();
        req_en = 1'b1;
        repeat (3) begin
            req_addr = $urandom;
            tick();
        end
        req_en = 1'b0;
        chk("waiting_before_reset", 128'(phase), 128'(1));
        do_reset();
        resp_ack = 1'b1;
        req_addr = 32'h0000_0050;
        req_en   = 1'b1;
        tick();
        req_en = 1'b0;
        repeat (6) tick();

        // Two requests and no ack for a long time. The response is either
        // held or dropped after the timeout, depending on the build.
        do_reset();
        req_en = 1'b1;
        repeat (2) begin
            req_addr = $urandom;
            tick();
        end
        req_en = 1'b0;
        repeat (40) tick();
        resp_ack = 1'b1;
        repeat (20) tick();

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
